// File: rtl/lt24_bus_sched_if.sv
// lt24_bus_sched_if: request ports, status and LT24 panel pins of the bus scheduler
interface lt24_bus_sched_if;
  logic        sw_reset;
  logic        lcd_en;
  logic        cfg_valid;
  logic        cfg_dc;
  logic [15:0] cfg_data;
  logic        cfg_ready;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready;
  logic        init_done;
  logic        busy;
  logic        lcd_cs_n;
  logic        lcd_wr_n;
  logic        lcd_rd_n;
  logic        lcd_dc_n;
  logic [15:0] lcd_d;
  logic        lcd_reset_n;
  logic        lcd_on;
  modport master (
    output sw_reset, lcd_en, cfg_valid, cfg_dc, cfg_data, pix_valid, pix_data,
    input  cfg_ready, pix_ready, init_done, busy, lcd_cs_n, lcd_wr_n, lcd_rd_n,
           lcd_dc_n, lcd_d, lcd_reset_n, lcd_on
  );
  modport slave (
    input  sw_reset, lcd_en, cfg_valid, cfg_dc, cfg_data, pix_valid, pix_data,
    output cfg_ready, pix_ready, init_done, busy, lcd_cs_n, lcd_wr_n, lcd_rd_n,
           lcd_dc_n, lcd_d, lcd_reset_n, lcd_on
  );
endinterface

// File: rtl/lt24_bus_sched.sv
// lt24_bus_sched: LT24 panel reset sequencer and config/pixel write-bus scheduler
module lt24_bus_sched #(
  parameter int RESET_LOW_CYC  = 500,
  parameter int RESET_WAIT_CYC = 6000000,
  parameter int WR_LOW_CYC     = 2,
  parameter int WR_HIGH_CYC    = 2
) (
  input logic clk_clk,
  input logic reset_reset_n,
  lt24_bus_sched_if.slave bus
);
  localparam int MAX_A = RESET_WAIT_CYC > RESET_LOW_CYC ? RESET_WAIT_CYC : RESET_LOW_CYC;
  localparam int MAX_B = WR_LOW_CYC > WR_HIGH_CYC ? WR_LOW_CYC : WR_HIGH_CYC;
  localparam int MAXC  = MAX_A > MAX_B ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAXC + 1);
  localparam logic [CW-1:0] L_RL = CW'(RESET_LOW_CYC - 1);
  localparam logic [CW-1:0] L_RW = CW'(RESET_WAIT_CYC - 1);
  localparam logic [CW-1:0] L_WL = CW'(WR_LOW_CYC - 1);
  localparam logic [CW-1:0] L_WH = CW'(WR_HIGH_CYC - 1);

  typedef enum logic [2:0] {RST_LOW, RST_WAIT, IDLE, WR_LOW, WR_HIGH} state_t;

  state_t        r_state, w_nxt;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_rst_n, r_cs_n, r_wr_n, r_dc_n, r_on, r_init, r_busy;
  logic [15:0]   r_d;
  logic          w_cfg_rdy, w_pix_rdy, w_cfg_acc, w_pix_acc, w_zero;

  assign w_cfg_rdy = (r_state == IDLE) & ~bus.sw_reset;
  assign w_pix_rdy = w_cfg_rdy & ~bus.cfg_valid;
  assign w_cfg_acc = w_cfg_rdy & bus.cfg_valid;
  assign w_pix_acc = w_pix_rdy & bus.pix_valid;
  assign w_zero    = (r_cnt == '0);

  assign bus.cfg_ready   = w_cfg_rdy;
  assign bus.pix_ready   = w_pix_rdy;
  assign bus.init_done   = r_init;
  assign bus.busy        = r_busy;
  assign bus.lcd_cs_n    = r_cs_n;
  assign bus.lcd_wr_n    = r_wr_n;
  assign bus.lcd_rd_n    = 1'b1;
  assign bus.lcd_dc_n    = r_dc_n;
  assign bus.lcd_d       = r_d;
  assign bus.lcd_reset_n = r_rst_n;
  assign bus.lcd_on      = r_on;

  // next state and counter reload; sw_reset overrides every state
  always_comb begin
    w_nxt = r_state;
    w_cnt = r_cnt - 1'b1;
    if (bus.sw_reset) begin
      w_nxt = RST_LOW;
      w_cnt = L_RL;
    end else begin
      case (r_state)
        RST_LOW:  if (w_zero) begin w_nxt = RST_WAIT; w_cnt = L_RW; end
        RST_WAIT: if (w_zero) w_nxt = IDLE;
        IDLE:     if (w_cfg_acc | w_pix_acc) begin w_nxt = WR_LOW; w_cnt = L_WL; end
        WR_LOW:   if (w_zero) begin w_nxt = WR_HIGH; w_cnt = L_WH; end
        WR_HIGH:  if (w_zero) w_nxt = IDLE;
        default:  w_nxt = RST_LOW;
      endcase
    end
  end

  // state register; pin outputs are decoded from the next state so they are registered
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= RST_LOW;
      r_cnt   <= L_RL;
      r_rst_n <= 1'b0;
      r_cs_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_dc_n  <= 1'b1;
      r_d     <= '0;
      r_on    <= 1'b0;
      r_init  <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt;
      r_rst_n <= w_nxt != RST_LOW;
      r_cs_n  <= !(w_nxt == WR_LOW || w_nxt == WR_HIGH);
      r_wr_n  <= w_nxt != WR_LOW;
      r_init  <= (w_nxt == IDLE) || (r_init && w_nxt != RST_LOW);
      r_busy  <= w_nxt != IDLE;
      r_on    <= bus.lcd_en;
      r_d     <= w_cfg_acc ? bus.cfg_data : w_pix_acc ? bus.pix_data : r_d;
      r_dc_n  <= w_cfg_acc ? bus.cfg_dc : w_pix_acc ? 1'b1 : r_dc_n;
    end
  end
endmodule

// File: tb/tb_lt24_bus_sched.sv
// tb_lt24_bus_sched: scoreboard bench for the LT24 bus scheduler
module tb_lt24_bus_sched;
  logic clk = 1'b0;
  logic reset_reset_n = 1'b0;
  initial forever #5 clk = ~clk;

  lt24_bus_sched_if bus();

  lt24_bus_sched #(
    .RESET_LOW_CYC(4), .RESET_WAIT_CYC(10), .WR_LOW_CYC(2), .WR_HIGH_CYC(2)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(reset_reset_n),
    .bus(bus)
  );

  int n_tests = 0, n_fail = 0;
  int cyc = 0, n_wr = 0, n_abort = 0, n_viol = 0, n_early = 0, n_prdy = 0;
  logic [16:0] sb[$];
  logic en_q = 1'b0, rst_q = 1'b0;
  logic prev_wr = 1'b1, in_high = 1'b0;
  int low_len = 0, high_len = 0;
  logic [16:0] e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    en_q = bus.lcd_en;
    rst_q = reset_reset_n;
  end

  initial begin
    bus.lcd_en = 1'b0;
    forever begin
      repeat (7) @(posedge clk);
      #1 bus.lcd_en = ~bus.lcd_en;
    end
  end

  // monitor: pops expected words on every wr_n rising edge and checks strobe timing
  initial forever begin
    @(negedge clk);
    if (!reset_reset_n) begin
      prev_wr = 1'b1; in_high = 1'b0; low_len = 0;
      continue;
    end
    if (rst_q) check("lcd_on", bus.lcd_on, en_q);
    if (bus.pix_ready && bus.cfg_valid) n_viol++;
    if (!bus.init_done && (bus.cfg_ready || bus.pix_ready)) n_early++;
    if (bus.pix_ready && bus.pix_valid) n_prdy++;
    if (!bus.lcd_wr_n) begin
      low_len++;
      check("cs_in_wr_low", bus.lcd_cs_n, 1'b0);
    end else if (!prev_wr) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_pop: wr_n rose with d=%h but no word expected", bus.lcd_d);
      end else begin
        e = sb.pop_front();
        if (!bus.lcd_cs_n) begin
          check("wr_low_len", low_len, 2);
          check("lcd_d", bus.lcd_d, e[15:0]);
          check("lcd_dc_n", bus.lcd_dc_n, e[16]);
          n_wr++; in_high = 1'b1; high_len = 1;
        end else begin
          n_abort++; in_high = 1'b0;
        end
      end
      low_len = 0;
    end else if (in_high) begin
      if (!bus.lcd_cs_n) high_len++;
      else begin
        check("wr_high_len", high_len, 2);
        in_high = 1'b0;
      end
    end
    prev_wr = bus.lcd_wr_n;
  end

  task automatic wait_init(input bit cfg_in_wait);
    int lo = 0, hi = 0;
    bit bad = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.lcd_cs_n !== 1'b1 || bus.lcd_wr_n !== 1'b1) bad = 1;
      if (bus.init_done) break;
      if (!bus.lcd_reset_n) lo++;
      else begin
        hi++;
        if (cfg_in_wait && hi == 3) bus.cfg_valid = 1'b1;
      end
    end
    check("init_done", bus.init_done, 1'b1);
    check("reset_low_cycles", lo, 4);
    check("reset_wait_cycles", hi, 10);
    check("bus_idle_in_reset", bad, 1'b0);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    check("idle_reached", bus.busy, 1'b0);
  endtask

  task automatic send_cfg(input logic dc, input logic [15:0] d, output int t);
    sb.push_back({dc, d});
    bus.cfg_dc = dc; bus.cfg_data = d; bus.cfg_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.cfg_ready) break;
    end
    check("cfg_accept", bus.cfg_ready, 1'b1);
    t = cyc;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
  endtask

  task automatic send_pix(input logic [15:0] d, output int t);
    sb.push_back({1'b1, d});
    bus.pix_data = d; bus.pix_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.pix_ready) break;
    end
    check("pix_accept", bus.pix_ready, 1'b1);
    t = cyc;
    @(posedge clk); #1;
  endtask

  initial begin
    int t0, t1, nb;
    int tp[8];
    bus.sw_reset = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_dc = 1'b0; bus.cfg_data = '0;
    bus.pix_valid = 1'b0; bus.pix_data = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_lcd_reset_n", bus.lcd_reset_n, 1'b0);
    check("rst_cs_n", bus.lcd_cs_n, 1'b1);
    check("rst_wr_n", bus.lcd_wr_n, 1'b1);
    check("rst_rd_n", bus.lcd_rd_n, 1'b1);
    check("rst_dc_n", bus.lcd_dc_n, 1'b1);
    check("rst_d", bus.lcd_d, 16'h0);
    check("rst_lcd_on", bus.lcd_on, 1'b0);
    check("rst_cfg_ready", bus.cfg_ready, 1'b0);
    check("rst_pix_ready", bus.pix_ready, 1'b0);
    check("rst_init_done", bus.init_done, 1'b0);
    check("rst_busy", bus.busy, 1'b1);
    reset_reset_n = 1'b1;
    // 1: power-on reset sequence
    wait_init(0);
    // 2: single command write
    @(posedge clk); #1;
    send_cfg(1'b0, 16'h002C, t0);
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
      nb++;
    end
    check("busy_cycles", nb, 4);
    // 3: config wins over simultaneous pixel
    @(posedge clk); #1;
    bus.pix_data = 16'hF800; bus.pix_valid = 1'b1;
    send_cfg(1'b1, 16'h0001, t0);
    send_pix(16'hF800, t1);
    bus.pix_valid = 1'b0;
    check("cfg_then_pix_gap", t1 - t0, 5);
    // 4: back-to-back pixel burst
    n_prdy = 0;
    for (int i = 0; i < 8; i++) begin
      send_pix(16'(i), tp[i]);
      if (i > 0) check("pix_spacing", tp[i] - tp[i-1], 5);
    end
    bus.pix_valid = 1'b0;
    wait_idle();
    check("pix_ready_cycles", n_prdy, 8);
    // 5: sw_reset aborts a pixel write; pending pixel waits for init
    @(posedge clk); #1;
    send_pix(16'h1234, t0);
    bus.pix_data = 16'h5678;
    sb.push_back({1'b1, 16'h5678});
    bus.sw_reset = 1'b1;
    @(posedge clk); #1;
    bus.sw_reset = 1'b0;
    check("swr_wr_n", bus.lcd_wr_n, 1'b1);
    check("swr_cs_n", bus.lcd_cs_n, 1'b1);
    check("swr_lcd_reset_n", bus.lcd_reset_n, 1'b0);
    check("swr_init_done", bus.init_done, 1'b0);
    wait_init(0);
    check("pix_first_idle_ready", bus.pix_ready, 1'b1);
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    wait_idle();
    // 6: config offered during RST_WAIT is stalled then accepted on first IDLE cycle
    @(posedge clk); #1;
    sb.push_back({1'b0, 16'h0029});
    bus.cfg_dc = 1'b0; bus.cfg_data = 16'h0029;
    bus.sw_reset = 1'b1;
    @(posedge clk); #1;
    bus.sw_reset = 1'b0;
    wait_init(1);
    check("cfg_first_idle_ready", bus.cfg_ready, 1'b1);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    check("writes_done", n_wr, 13);
    check("aborts", n_abort, 1);
    check("pix_ready_with_cfg", n_viol, 0);
    check("ready_before_init", n_early, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lt24_bus_sched.md
Name: lt24_bus_sched

Overview:
- Scheduler and bus sequencer for the LT24 LCD 8080-style write interface (cs_n, wr_n, dc_n, rd_n, d[15:0], reset, lcd_on).
- Runs the panel hardware-reset sequence, then shares the write-only bus between two requesters:
  - a configuration port for command and parameter writes (HPS/Avalon side);
  - a pixel stream port for frame data.
- Sits between the LCD register/stream logic and the top-level lt24 conduit pins.

Parameters:
RESET_LOW_CYC, 500, cycles lcd_reset_n is held low (10 us at 50 MHz); legal range >=1
RESET_WAIT_CYC, 6000000, cycles waited after reset release before any write (120 ms at 50 MHz); legal range >=1
WR_LOW_CYC, 2, cycles wr_n is held low per word; legal range >=1
WR_HIGH_CYC, 2, cycles wr_n is held high (data held) after the rising edge; legal range >=1

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
sw_reset  in  1  synchronous request to re-run the panel reset sequence
lcd_en  in  1  backlight/display enable request
cfg_valid  in  1  config word available
cfg_dc  in  1  0 = command, 1 = parameter data
cfg_data  in  16  config word
cfg_ready  out  1  config word accepted when high together with cfg_valid
pix_valid  in  1  pixel word available
pix_data  in  16  RGB565 pixel
pix_ready  out  1  pixel accepted when high together with pix_valid
init_done  out  1  panel reset sequence complete
busy  out  1  high in any state other than IDLE
lcd_cs_n  out  1  chip select, active low
lcd_wr_n  out  1  write strobe; panel latches on its rising edge
lcd_rd_n  out  1  read strobe; constant 1
lcd_dc_n  out  1  0 = command, 1 = data
lcd_d  out  16  bus data
lcd_reset_n  out  1  panel reset, active low
lcd_on  out  1  registered copy of lcd_en

Behaviour:
- Reset (reset_reset_n = 0, asynchronous):
  - state = RST_LOW, counter loaded;
  - lcd_reset_n = 0, lcd_cs_n = 1, lcd_wr_n = 1, lcd_rd_n = 1, lcd_dc_n = 1, lcd_d = 0;
  - lcd_on = 0, cfg_ready = 0, pix_ready = 0, init_done = 0, busy = 1.
- All outputs are registered except cfg_ready and pix_ready.
- Counter width = clog2(max(RESET_WAIT_CYC, RESET_LOW_CYC, WR_LOW_CYC, WR_HIGH_CYC) + 1).
- States:
  - RST_LOW: lcd_reset_n = 0 for RESET_LOW_CYC cycles, then RST_WAIT.
  - RST_WAIT: lcd_reset_n = 1 for RESET_WAIT_CYC cycles, then IDLE; init_done is set on entry to IDLE and stays set until the next reset or sw_reset.
  - IDLE: cs_n = 1, wr_n = 1.
    - cfg_ready = !sw_reset.
    - pix_ready = !sw_reset & !cfg_valid. Fixed priority to config; this is the only combinational path.
    - On an accepted word (valid & ready) in cycle T: latch data and dc (pixel forces dc = 1); go to WR_LOW.
  - WR_LOW: from cycle T+1, cs_n = 0, wr_n = 0, lcd_d and lcd_dc_n driven from the latch, for WR_LOW_CYC cycles; then WR_HIGH.
  - WR_HIGH: cs_n = 0, wr_n = 1, d/dc held, for WR_HIGH_CYC cycles; then IDLE.
- Word period = 1 + WR_LOW_CYC + WR_HIGH_CYC cycles (5 at defaults). cfg_ready and pix_ready are 0 outside IDLE.
- Requesters must not make valid depend on ready.
- Data, once offered, must be held until accepted. The block does not check this.
- lcd_d and lcd_dc_n hold their last written value in IDLE.
- sw_reset, sampled in any state:
  - next cycle: state = RST_LOW, lcd_reset_n = 0, cs_n = 1, wr_n = 1, init_done = 0;
  - an in-flight write is aborted; truncation is acceptable because the panel is reset;
  - holding sw_reset high keeps the block in RST_LOW with the counter reloaded.
- Simultaneous cfg_valid and pix_valid in IDLE: config is granted; pixels wait. No fairness guarantee; software keeps config traffic sparse.
- Words offered before init_done are stalled (ready = 0), never dropped.
- lcd_on follows lcd_en with 1-cycle latency, independent of state, including during the reset sequence.

Test Plan:
1. RESET_LOW_CYC=4, RESET_WAIT_CYC=10; release reset_reset_n -> lcd_reset_n low for exactly 4 cycles, then high; init_done rises 10 cycles after lcd_reset_n rises; cs_n/wr_n stay 1 throughout.
2. After init, cfg_valid=1, cfg_dc=0, cfg_data=0x002C for one accepted cycle -> lcd_dc_n=0, lcd_d=0x002C, wr_n low 2 cycles then high 2 cycles with cs_n=0 across all 4; busy returns to 0 at the 5th cycle after acceptance.
3. cfg_valid and pix_valid both high (cfg_dc=1, cfg_data=0x0001; pix_data=0xF800) -> cfg written first with dc_n=1; pixel 0xF800 accepted 5 cycles later; pix_ready never high while cfg_valid=1.
4. Continuous pix_valid with 8 pixels 0x0000..0x0007 -> 8 wr_n rising edges spaced 5 cycles apart, data in order, dc_n=1; pix_ready high exactly 8 cycles total.
5. sw_reset pulsed during a pixel's WR_LOW -> next cycle wr_n=1, cs_n=1, lcd_reset_n=0, init_done=0; the full reset sequence repeats; a pending pix_valid is accepted only after init_done.
6. cfg_valid=1 asserted during RST_WAIT -> cfg_ready stays 0 until init_done; word accepted in the first IDLE cycle. Toggle lcd_en -> lcd_on follows 1 cycle later in any state.
